// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the memory stage and the data-memory controller.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; resp_valid is a one-cycle pulse.
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              MemRead;
  logic              MemWrite;
  logic [2:0]        Funct3;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              resp_valid;
  logic [DATA_W-1:0] rd_data;
  logic              err;

  modport master (
    output req_valid, MemRead, MemWrite, Funct3, addr, wr_data,
    input  req_ready, resp_valid, rd_data, err
  );

  modport slave (
    input  req_valid, MemRead, MemWrite, Funct3, addr, wr_data,
    output req_ready, resp_valid, rd_data, err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte/half/word data-memory controller over a 2**ADDR_W byte little-endian array,
// with WAIT_STATES programmable cycles between request acceptance and the access.
module data_mem_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 1
) (
  input  logic                clk,
  input  logic                reset,
  data_mem_ctrl_if.slave      bus,
  output logic                busy,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              q_rd, q_wr;
  logic [2:0]        q_f3;
  logic [ADDR_W-1:0] q_addr;
  logic [DATA_W-1:0] q_wdata;
  logic [DATA_W-1:0] rd_q;
  logic              err_q;

  logic [7:0]        mem [2**ADDR_W];

  logic              accept, access, req_err, mis, bad_f3, do_write;
  logic [ADDR_W-1:0] a_b1, a_b2, a_b3;
  logic [7:0]        b0, b1, b2, b3;
  logic [DATA_W-1:0] load_val;

  // A new request is also taken in the RESP cycle so back-to-back requests lose no cycle.
  assign accept = bus.req_valid && (bus.MemRead || bus.MemWrite) &&
                  (state == S_IDLE || state == S_RESP);
  assign access = (state == S_WAIT) && (cnt == 4'd0);

  assign mis    = ((q_f3[1:0] == 2'b01) && q_addr[0]) ||
                  ((q_f3[1:0] == 2'b10) && (q_addr[1:0] != 2'b00));
  assign bad_f3 = q_rd ? ((q_f3 == 3'b011) || (q_f3[2:1] == 2'b11))
                       : (q_f3[2] || (q_f3[1:0] == 2'b11));
  assign req_err = (q_rd && q_wr) || bad_f3 || mis;

  // Upper byte lanes are only meaningful for aligned accesses, so they are formed by OR-ing the offset.
  assign a_b1 = {q_addr[ADDR_W-1:1], 1'b1};
  assign a_b2 = {q_addr[ADDR_W-1:2], 2'b10};
  assign a_b3 = {q_addr[ADDR_W-1:2], 2'b11};
  assign b0   = mem[q_addr];
  assign b1   = mem[a_b1];
  assign b2   = mem[a_b2];
  assign b3   = mem[a_b3];

  always_comb begin
    load_val = '0;
    case (q_f3)
      3'b000:  load_val = {{24{b0[7]}}, b0};
      3'b001:  load_val = {{16{b1[7]}}, b1, b0};
      3'b010:  load_val = {b3, b2, b1, b0};
      3'b100:  load_val = {24'b0, b0};
      3'b101:  load_val = {16'b0, b1, b0};
      default: load_val = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_WAIT;
      S_WAIT:  if (cnt == 4'd0) state_nxt = S_RESP;
      S_RESP:  state_nxt = accept ? S_WAIT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    bus.req_ready  = (state != S_WAIT);
    bus.resp_valid = (state == S_RESP);
    busy           = (state != S_IDLE);
    state_dbg      = state;
  end

  assign bus.rd_data = rd_q;
  assign bus.err     = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= 4'd0;
      q_rd    <= 1'b0;
      q_wr    <= 1'b0;
      q_f3    <= 3'b000;
      q_addr  <= '0;
      q_wdata <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        q_rd    <= bus.MemRead;
        q_wr    <= bus.MemWrite;
        q_f3    <= bus.Funct3;
        q_addr  <= bus.addr;
        q_wdata <= bus.wr_data;
        cnt     <= 4'(WAIT_STATES);
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        err_q <= req_err;
        if (req_err)   rd_q <= '0;
        else if (q_rd) rd_q <= load_val;
      end
    end
  end

  // Reset sampled high at the access edge suppresses the write.
  assign do_write = access && q_wr && !req_err && !reset;

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[q_addr] <= q_wdata[7:0];
      if (q_f3[1:0] != 2'b00) mem[a_b1] <= q_wdata[15:8];
      if (q_f3[1:0] == 2'b10) begin
        mem[a_b2] <= q_wdata[23:16];
        mem[a_b3] <= q_wdata[31:24];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl at WAIT_STATES = 0, 1 and 15 with a byte-array
// reference model feeding an expected-response queue.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic busy0, busy1, busy15;
  logic [1:0] st0, st1, st15;

  int n_vec = 0;
  int n_err = 0;

  logic [32:0] exp_q[$];
  logic [7:0]  model_mem [3][512];
  logic [31:0] model_rd  [3];
  logic [31:0] obs;

  always #5 clk = ~clk;

  data_mem_ctrl_if #(.ADDR_W(9), .DATA_W(32)) b0 ();
  data_mem_ctrl_if #(.ADDR_W(9), .DATA_W(32)) b1 ();
  data_mem_ctrl_if #(.ADDR_W(9), .DATA_W(32)) b2 ();

  data_mem_ctrl #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(b0), .busy(busy0), .state_dbg(st0));
  data_mem_ctrl #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1), .busy(busy1), .state_dbg(st1));
  data_mem_ctrl #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(15)) dut15 (
    .clk(clk), .reset(reset), .bus(b2), .busy(busy15), .state_dbg(st15));

  function automatic int ws_of(input int s);
    return (s == 0) ? 0 : (s == 1) ? 1 : 15;
  endfunction

  function automatic logic get_rv(input int s);
    return (s == 0) ? b0.resp_valid : (s == 1) ? b1.resp_valid : b2.resp_valid;
  endfunction
  function automatic logic get_ready(input int s);
    return (s == 0) ? b0.req_ready : (s == 1) ? b1.req_ready : b2.req_ready;
  endfunction
  function automatic logic get_err(input int s);
    return (s == 0) ? b0.err : (s == 1) ? b1.err : b2.err;
  endfunction
  function automatic logic [31:0] get_rd(input int s);
    return (s == 0) ? b0.rd_data : (s == 1) ? b1.rd_data : b2.rd_data;
  endfunction
  function automatic logic get_busy(input int s);
    return (s == 0) ? busy0 : (s == 1) ? busy1 : busy15;
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic set_req(input int s, input logic v, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [8:0] a, input logic [31:0] d);
    case (s)
      0: begin b0.req_valid = v; b0.MemRead = rd; b0.MemWrite = wr;
               b0.Funct3 = f3; b0.addr = a; b0.wr_data = d; end
      1: begin b1.req_valid = v; b1.MemRead = rd; b1.MemWrite = wr;
               b1.Funct3 = f3; b1.addr = a; b1.wr_data = d; end
      default: begin b2.req_valid = v; b2.MemRead = rd; b2.MemWrite = wr;
               b2.Funct3 = f3; b2.addr = a; b2.wr_data = d; end
    endcase
  endtask

  // Reference model: returns {err, rd_data} for the response and updates model state.
  task automatic model(input int s, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [8:0] a, input logic [31:0] d, output logic [32:0] e);
    logic bad;
    logic [31:0] v;
    bad = rd && wr;
    if (rd && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) bad = 1'b1;
    if (wr && !(f3 inside {3'b000, 3'b001, 3'b010})) bad = 1'b1;
    if (f3[1:0] == 2'b01 && a[0]) bad = 1'b1;
    if (f3[1:0] == 2'b10 && a[1:0] != 2'b00) bad = 1'b1;
    if (bad) begin
      model_rd[s] = 32'h0;
      e = {1'b1, 32'h0};
    end else if (rd) begin
      case (f3)
        3'b000: v = {{24{model_mem[s][a][7]}}, model_mem[s][a]};
        3'b100: v = {24'h0, model_mem[s][a]};
        3'b001: v = {{16{model_mem[s][a+1][7]}}, model_mem[s][a+1], model_mem[s][a]};
        3'b101: v = {16'h0, model_mem[s][a+1], model_mem[s][a]};
        default: v = {model_mem[s][a+3], model_mem[s][a+2], model_mem[s][a+1], model_mem[s][a]};
      endcase
      model_rd[s] = v;
      e = {1'b0, v};
    end else begin
      model_mem[s][a] = d[7:0];
      if (f3 != 3'b000) model_mem[s][a+1] = d[15:8];
      if (f3 == 3'b010) begin
        model_mem[s][a+2] = d[23:16];
        model_mem[s][a+3] = d[31:24];
      end
      e = {1'b0, model_rd[s]};
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic issue(input int s, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [8:0] a, input logic [31:0] d);
    logic [32:0] e;
    set_req(s, 1'b1, rd, wr, f3, a, d);
    chk("req_ready_at_issue", 64'(get_ready(s)), 64'h1);
    model(s, rd, wr, f3, a, d, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    set_req(s, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 9'($urandom_range(0, 511)), $urandom);
    @(negedge clk);
  endtask

  task automatic await_resp(input int s, input logic idle_after, output logic [31:0] o);
    int k;
    logic seen;
    logic [32:0] e;
    k = 0;
    seen = 1'b0;
    o = 32'h0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (get_rv(s)) seen = 1'b1;
      else chk("req_ready_in_wait", 64'(get_ready(s)), 64'h0);
    end
    chk("resp_seen", 64'(seen), 64'h1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
    if (seen) begin
      chk("latency", 64'(k), 64'(ws_of(s) + 1));
      chk("resp_err", 64'(get_err(s)), 64'(e[32]));
      chk("resp_rd_data", 64'(get_rd(s)), 64'(e[31:0]));
      o = get_rd(s);
      if (idle_after) begin
        @(negedge clk);
        chk("resp_one_cycle", 64'(get_rv(s)), 64'h0);
        chk("busy_after_resp", 64'(get_busy(s)), 64'h0);
      end
    end
  endtask

  task automatic op(input int s, input logic rd, input logic wr, input logic [2:0] f3,
                    input logic [8:0] a, input logic [31:0] d, output logic [31:0] o);
    issue(s, rd, wr, f3, a, d);
    await_resp(s, 1'b1, o);
  endtask

  initial begin
    reset = 1'b1;
    for (int s = 0; s < 3; s++) begin
      set_req(s, 1'b0, 1'b0, 1'b0, 3'b000, 9'h0, 32'h0);
      model_rd[s] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("reset_req_ready", 64'(get_ready(s)), 64'h1);
      chk("reset_resp_valid", 64'(get_rv(s)), 64'h0);
      chk("reset_busy", 64'(get_busy(s)), 64'h0);
      chk("reset_rd_data", 64'(get_rd(s)), 64'h0);
      chk("reset_err", 64'(get_err(s)), 64'h0);
    end
    reset = 1'b0;
    @(negedge clk);

    // WAIT_STATES = 1: stores, loads of every width/sign, partial stores
    op(1, 0, 1, 3'b010, 9'h1FC, 32'hA5A5A5A5, obs);
    op(1, 0, 1, 3'b010, 9'h020, 32'hCAFEF00D, obs);
    op(1, 0, 1, 3'b010, 9'h010, 32'hDEADBEEF, obs);
    chk("sw_resp_rd_unchanged", 64'(obs), 64'h0);
    op(1, 1, 0, 3'b010, 9'h010, 32'h0, obs);
    chk("lw_010", 64'(obs), 64'hDEADBEEF);
    op(1, 1, 0, 3'b000, 9'h010, 32'h0, obs);
    chk("lb_010", 64'(obs), 64'hFFFFFFEF);
    op(1, 1, 0, 3'b100, 9'h013, 32'h0, obs);
    chk("lbu_013", 64'(obs), 64'h000000DE);
    op(1, 1, 0, 3'b001, 9'h012, 32'h0, obs);
    chk("lh_012", 64'(obs), 64'hFFFFDEAD);
    op(1, 1, 0, 3'b101, 9'h010, 32'h0, obs);
    chk("lhu_010", 64'(obs), 64'h0000BEEF);
    op(1, 0, 1, 3'b000, 9'h011, 32'h12345678, obs);
    chk("sb_resp_rd_held", 64'(obs), 64'h0000BEEF);
    op(1, 1, 0, 3'b010, 9'h010, 32'h0, obs);
    chk("lw_after_sb", 64'(obs), 64'hDEAD78EF);
    op(1, 0, 1, 3'b001, 9'h012, 32'h0000AAAA, obs);
    op(1, 1, 0, 3'b010, 9'h010, 32'h0, obs);
    chk("lw_after_sh", 64'(obs), 64'hAAAA78EF);

    // Error responses
    op(1, 1, 0, 3'b010, 9'h012, 32'h0, obs);
    chk("lw_misaligned_rd", 64'(obs), 64'h0);
    op(1, 0, 1, 3'b001, 9'h1FF, 32'h0000FFFF, obs);
    op(1, 1, 0, 3'b010, 9'h1FC, 32'h0, obs);
    chk("lw_1fc_untouched", 64'(obs), 64'hA5A5A5A5);
    op(1, 1, 0, 3'b011, 9'h010, 32'h0, obs);
    op(1, 1, 1, 3'b010, 9'h010, 32'h0, obs);
    op(1, 0, 1, 3'b100, 9'h010, 32'h0, obs);
    op(1, 1, 0, 3'b010, 9'h010, 32'h0, obs);
    chk("lw_after_bad_store", 64'(obs), 64'hAAAA78EF);

    // Request with neither MemRead nor MemWrite is not taken
    set_req(1, 1'b1, 1'b0, 1'b0, 3'b010, 9'h010, 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("no_op_busy", 64'(get_busy(1)), 64'h0);
      chk("no_op_resp", 64'(get_rv(1)), 64'h0);
    end
    set_req(1, 1'b0, 1'b0, 1'b0, 3'b000, 9'h0, 32'h0);

    // WAIT_STATES = 0 and 15
    op(0, 0, 1, 3'b010, 9'h040, 32'h55AA55AA, obs);
    op(0, 1, 0, 3'b010, 9'h040, 32'h0, obs);
    chk("ws0_lw", 64'(obs), 64'h55AA55AA);
    op(2, 0, 1, 3'b010, 9'h040, 32'h0BADCAFE, obs);
    op(2, 1, 0, 3'b001, 9'h042, 32'h0, obs);
    chk("ws15_lh", 64'(obs), 64'h00000BAD);

    // Back-to-back: second request presented in the RESP cycle of the first
    issue(2, 1, 0, 3'b010, 9'h040, 32'h0);
    await_resp(2, 1'b0, obs);
    issue(2, 1, 0, 3'b100, 9'h043, 32'h0);
    await_resp(2, 1'b1, obs);
    chk("b2b_lbu", 64'(obs), 64'h0000000B);

    // Reset in WAIT aborts the store; reset again on a store's access edge
    for (int n = 0; n < 2; n++) begin
      set_req(1, 1'b1, 1'b0, 1'b1, 3'b010, 9'h020, 32'h11223344);
      @(posedge clk);
      #1;
      set_req(1, 1'b0, 1'b0, 1'b0, 3'b000, 9'h0, 32'h0);
      @(negedge clk);
      if (n == 1) @(negedge clk);
      chk("abort_in_wait", 64'(st1), 64'h1);
      reset = 1'b1;
      #1;
      chk("abort_req_ready", 64'(get_ready(1)), 64'h1);
      chk("abort_busy", 64'(get_busy(1)), 64'h0);
      chk("abort_rd_data", 64'(get_rd(1)), 64'h0);
      chk("abort_err", 64'(get_err(1)), 64'h0);
      repeat (2) begin
        @(negedge clk);
        chk("abort_no_resp", 64'(get_rv(1)), 64'h0);
      end
      reset = 1'b0;
      for (int s = 0; s < 3; s++) model_rd[s] = 32'h0;
      @(negedge clk);
      op(1, 1, 0, 3'b010, 9'h020, 32'h0, obs);
      chk("lw_020_prior", 64'(obs), 64'hCAFEF00D);
    end

    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
